// File: rtl/brc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : brc_pkg
//  Purpose  : Shared types and constants for the branch resolution controller.
//  Revision : 1.0  initial release
// ============================================================================
package brc_pkg;

    typedef enum logic [0:0] {
        TRACK   = 1'b0,
        RECOVER = 1'b1
    } brc_state_e;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam int BRC_XLEN = 32;

    typedef struct packed {
        logic                taken;
        logic [BRC_XLEN-1:0] tgt;
    } pred_entry_t;

    function automatic logic is_cf_opcode(input logic [6:0] opc);
        return (opc == OPC_BRANCH) || (opc == OPC_JAL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/brc_pred_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : brc_pred_fifo
//  Purpose  : In-order queue of in-flight predictions with push/pop/clear.
//  Revision : 1.0  initial release
// ============================================================================
module brc_pred_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    input  logic [WIDTH-1:0]             push_data,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         empty
);
    import brc_pkg::*;

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_full;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_full    = (r_count == c_CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];
    assign w_do_push = push & ~w_full & ~clear;
    assign w_do_pop  = pop & ~empty & ~clear;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            // Drop everything in flight; next entry lands where the write pointer already sits.
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolve_ctrl
//  Purpose  : Matches fetch-stage predictions with EX resolution; issues
//             flush/redirect on mispredict. Optional BRC_PERF_CNT_EN adds
//             branch / mispredict counters.
//  Revision : 1.0  initial release
// ============================================================================
module branch_resolve_ctrl #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_valid,
    input  logic            fetch_is_cf,
    input  logic            fetch_stall,
    input  logic            fetch_pred_taken,
    input  logic [XLEN-1:0] fetch_pred_tgt,
    input  logic            ex_valid,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic [XLEN-1:0] ex_pc_plus4,
    output logic            queue_full,
    output logic            state_update_en,
    output logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            underflow_err
`ifdef BRC_PERF_CNT_EN
    ,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispredict_cnt
`endif
);
    import brc_pkg::*;

    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    brc_state_e         r_state;
    brc_state_e         w_state_next;
    logic [XLEN:0]      w_head;
    logic [c_CNT_W-1:0] w_count;
    logic               w_empty;
    logic               w_in_track;
    logic               w_push;
    logic               w_pop;
    logic               w_mispredict;
    logic               r_flush;
    logic               r_redirect_valid;
    logic [XLEN-1:0]    r_redirect_pc;
    logic               r_underflow;

    assign w_in_track = (r_state == TRACK);
    assign queue_full = (w_count == c_CNT_W'(DEPTH));
    assign w_pop      = ex_valid & ~w_empty & w_in_track;

    // Head layout is {taken, tgt}; target only matters when the branch was actually taken.
    assign w_mispredict = w_pop & ((ex_taken != w_head[XLEN]) |
                                   (ex_taken & (ex_target != w_head[XLEN-1:0])));

    assign w_push = fetch_valid & fetch_is_cf & ~fetch_stall & ~queue_full &
                    w_in_track & ~w_mispredict;

    brc_pred_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN + 1)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .clear     (w_mispredict),
        .push_data ({fetch_pred_taken, fetch_pred_tgt}),
        .head_data (w_head),
        .count     (w_count),
        .empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= TRACK;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            TRACK:   if (w_mispredict) w_state_next = RECOVER;
            RECOVER: w_state_next = TRACK;
            default: w_state_next = TRACK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_underflow      <= 1'b0;
        end else begin
            r_flush          <= w_mispredict;
            r_redirect_valid <= w_mispredict;
            if (w_mispredict) begin
                r_redirect_pc <= ex_taken ? ex_target : ex_pc_plus4;
            end
            if (ex_valid & w_empty & w_in_track) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign state_update_en = w_pop;
    assign flush           = r_flush;
    assign redirect_valid  = r_redirect_valid;
    assign redirect_pc     = r_redirect_pc;
    assign underflow_err   = r_underflow;

`ifdef BRC_PERF_CNT_EN
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispredict_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (w_mispredict) begin
                r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
            end
        end
    end

    assign branch_cnt     = r_branch_cnt;
    assign mispredict_cnt = r_mispredict_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_resolve_ctrl
//  Purpose  : Directed self-checking bench for branch_resolve_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_branch_resolve_ctrl;

    logic        clk;
    logic        reset;
    logic        fetch_valid;
    logic        fetch_is_cf;
    logic        fetch_stall;
    logic        fetch_pred_taken;
    logic [31:0] fetch_pred_tgt;
    logic        ex_valid;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic [31:0] ex_pc_plus4;
    logic        queue_full;
    logic        state_update_en;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        underflow_err;
`ifdef BRC_PERF_CNT_EN
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;
`endif

    int total;
    int bad;

    branch_resolve_ctrl #(.DEPTH(4), .XLEN(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_valid      (fetch_valid),
        .fetch_is_cf      (fetch_is_cf),
        .fetch_stall      (fetch_stall),
        .fetch_pred_taken (fetch_pred_taken),
        .fetch_pred_tgt   (fetch_pred_tgt),
        .ex_valid         (ex_valid),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_pc_plus4      (ex_pc_plus4),
        .queue_full       (queue_full),
        .state_update_en  (state_update_en),
        .flush            (flush),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .underflow_err    (underflow_err)
`ifdef BRC_PERF_CNT_EN
        ,
        .branch_cnt       (branch_cnt),
        .mispredict_cnt   (mispredict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_valid      = 1'b0;
        fetch_is_cf      = 1'b0;
        fetch_stall      = 1'b0;
        fetch_pred_taken = 1'b0;
        fetch_pred_tgt   = 32'h0;
        ex_valid         = 1'b0;
        ex_taken         = 1'b0;
        ex_target        = 32'h0;
        ex_pc_plus4      = 32'h0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_push(input logic taken, input logic [31:0] tgt);
        fetch_valid      = 1'b1;
        fetch_is_cf      = 1'b1;
        fetch_pred_taken = taken;
        fetch_pred_tgt   = tgt;
    endtask

    task automatic set_ex(input logic taken, input logic [31:0] tgt, input logic [31:0] pc4);
        ex_valid    = 1'b1;
        ex_taken    = taken;
        ex_target   = tgt;
        ex_pc_plus4 = pc4;
    endtask

    // Pops not-taken resolutions until the queue reports empty; returns entries popped.
    task automatic drain(output int n);
        n = 0;
        fetch_valid = 1'b0;
        set_ex(1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            #1;
            if (state_update_en !== 1'b1) break;
            n++;
            tick();
        end
        tick();
        ex_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({flush, redirect_valid, underflow_err, queue_full, state_update_en} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {flush, redirect_valid, underflow_err, queue_full, state_update_en});
        end
        total++;
        if (redirect_pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_redirect_pc got=%h exp=00000000", redirect_pc);
        end
`ifdef BRC_PERF_CNT_EN
        total++;
        if (branch_cnt !== 32'h0 || mispredict_cnt !== 32'h0) begin
            bad++;
            $display("FAIL reset_perf got=%0d/%0d exp=0/0", branch_cnt, mispredict_cnt);
        end
`endif
        reset = 1'b0;
    endtask

    task automatic test_correct_predict();
        do_reset();
        set_push(1'b1, 32'h100);
        tick();
        idle();
        set_ex(1'b1, 32'h100, 32'h14);
        #1;
        total++;
        if (state_update_en !== 1'b1) begin
            bad++;
            $display("FAIL correct_update got=%b exp=1", state_update_en);
        end
        tick();
        total++;
        if (flush !== 1'b0 || redirect_valid !== 1'b0) begin
            bad++;
            $display("FAIL correct_noflush got=%b%b exp=00", flush, redirect_valid);
        end
        // queue must now be empty: another resolution pops nothing
        set_ex(1'b1, 32'h100, 32'h14);
        #1;
        total++;
        if (state_update_en !== 1'b0) begin
            bad++;
            $display("FAIL correct_empty_update got=%b exp=0", state_update_en);
        end
        tick();
        idle();
        total++;
        if (underflow_err !== 1'b1) begin
            bad++;
            $display("FAIL correct_empty_underflow got=%b exp=1", underflow_err);
        end
    endtask

    task automatic test_mispredict_taken();
        int n;
        do_reset();
        set_push(1'b0, 32'h0);
        tick();
        idle();
        set_ex(1'b1, 32'h200, 32'h44);
        #1;
        total++;
        if (state_update_en !== 1'b1) begin
            bad++;
            $display("FAIL mp_taken_update got=%b exp=1", state_update_en);
        end
        tick();
        total++;
        if (flush !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h200) begin
            bad++;
            $display("FAIL mp_taken_redirect got=%b%b pc=%h exp=11 pc=00000200",
                     flush, redirect_valid, redirect_pc);
        end
        // RECOVER cycle: resolution and fetch push are both ignored
        set_push(1'b0, 32'h55);
        set_ex(1'b0, 32'h0, 32'h0);
        #1;
        total++;
        if (state_update_en !== 1'b0) begin
            bad++;
            $display("FAIL mp_recover_update got=%b exp=0", state_update_en);
        end
        tick();
        idle();
        total++;
        if (flush !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'h200 || underflow_err !== 1'b0) begin
            bad++;
            $display("FAIL mp_recover_after got=%b%b%b pc=%h exp=000 pc=00000200",
                     flush, redirect_valid, underflow_err, redirect_pc);
        end
        drain(n);
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL mp_recover_push_dropped got=%0d exp=0", n);
        end
    endtask

    task automatic test_mispredict_not_taken();
        int n;
        do_reset();
        set_push(1'b1, 32'h300);
        tick();
        set_push(1'b0, 32'h304);
        tick();
        set_push(1'b0, 32'h308);
        tick();
        idle();
        set_ex(1'b0, 32'h0, 32'h48);
        tick();
        idle();
        total++;
        if (flush !== 1'b1 || redirect_pc !== 32'h48) begin
            bad++;
            $display("FAIL mp_nt_redirect got=%b pc=%h exp=1 pc=00000048", flush, redirect_pc);
        end
        tick();
        drain(n);
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL mp_nt_cleared got=%0d exp=0", n);
        end
    endtask

    task automatic test_target_mismatch();
        do_reset();
        set_push(1'b1, 32'h700);
        tick();
        idle();
        set_ex(1'b1, 32'h704, 32'h80);
        tick();
        idle();
        total++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h704) begin
            bad++;
            $display("FAIL tgt_mismatch got=%b pc=%h exp=1 pc=00000704", redirect_valid, redirect_pc);
        end
    endtask

    task automatic test_full();
        int n;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_push(1'b0, 32'h10 * i);
            tick();
            total++;
            if (queue_full !== (i == 3)) begin
                bad++;
                $display("FAIL full_fill[%0d] got=%b exp=%b", i, queue_full, (i == 3));
            end
        end
        set_push(1'b0, 32'hF0);
        tick();
        total++;
        if (queue_full !== 1'b1) begin
            bad++;
            $display("FAIL full_fifth got=%b exp=1", queue_full);
        end
        fetch_valid = 1'b0;
        set_ex(1'b0, 32'h0, 32'h0);
        tick();
        total++;
        if (queue_full !== 1'b0) begin
            bad++;
            $display("FAIL full_after_pop got=%b exp=0", queue_full);
        end
        set_push(1'b0, 32'hA0);
        tick();
        total++;
        if (queue_full !== 1'b0) begin
            bad++;
            $display("FAIL full_push_pop got=%b exp=0", queue_full);
        end
        ex_valid = 1'b0;
        tick();
        total++;
        if (queue_full !== 1'b1) begin
            bad++;
            $display("FAIL full_refill got=%b exp=1", queue_full);
        end
        fetch_valid = 1'b0;
        drain(n);
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL full_drain got=%0d exp=4", n);
        end
    endtask

    task automatic test_stall();
        int n;
        do_reset();
        set_push(1'b0, 32'h20);
        fetch_stall = 1'b1;
        tick();
        fetch_stall = 1'b0;
        fetch_is_cf = 1'b0;
        tick();
        idle();
        drain(n);
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL stall_no_push got=%0d exp=0", n);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        total++;
        if (underflow_err !== 1'b0) begin
            bad++;
            $display("FAIL uf_initial got=%b exp=0", underflow_err);
        end
        set_ex(1'b1, 32'h40, 32'h8);
        #1;
        total++;
        if (state_update_en !== 1'b0) begin
            bad++;
            $display("FAIL uf_update got=%b exp=0", state_update_en);
        end
        tick();
        idle();
        repeat (3) tick();
        set_push(1'b0, 32'h0);
        tick();
        idle();
        set_ex(1'b0, 32'h0, 32'h0);
        tick();
        idle();
        total++;
        if (underflow_err !== 1'b1) begin
            bad++;
            $display("FAIL uf_sticky got=%b exp=1", underflow_err);
        end
        do_reset();
        total++;
        if (underflow_err !== 1'b0) begin
            bad++;
            $display("FAIL uf_cleared got=%b exp=0", underflow_err);
        end
    endtask

    task automatic test_mispredict_concurrent_push();
        int n;
        do_reset();
        set_push(1'b0, 32'h0);
        tick();
        set_push(1'b1, 32'h900);
        set_ex(1'b1, 32'h500, 32'h24);
        tick();
        idle();
        total++;
        if (flush !== 1'b1 || redirect_pc !== 32'h500) begin
            bad++;
            $display("FAIL conc_redirect got=%b pc=%h exp=1 pc=00000500", flush, redirect_pc);
        end
`ifdef BRC_PERF_CNT_EN
        total++;
        if (branch_cnt !== 32'd1 || mispredict_cnt !== 32'd1) begin
            bad++;
            $display("FAIL conc_perf got=%0d/%0d exp=1/1", branch_cnt, mispredict_cnt);
        end
`endif
        tick();
        drain(n);
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL conc_push_dropped got=%0d exp=0", n);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_push(1'b1, 32'h1000);
        tick();
        for (int i = 1; i < 6; i++) begin
            set_push(1'b1, 32'h1000 + 32'h10 * i);
            set_ex(1'b1, 32'h1000 + 32'h10 * (i - 1), 32'h0);
            #1;
            total++;
            if (state_update_en !== 1'b1) begin
                bad++;
                $display("FAIL b2b_update[%0d] got=%b exp=1", i, state_update_en);
            end
            tick();
            total++;
            if (flush !== 1'b0 || queue_full !== 1'b0) begin
                bad++;
                $display("FAIL b2b_state[%0d] got=%b%b exp=00", i, flush, queue_full);
            end
        end
        idle();
    endtask

    task automatic test_reset_cancels_redirect();
        do_reset();
        set_push(1'b0, 32'h0);
        tick();
        idle();
        set_ex(1'b1, 32'h600, 32'h4);
        reset = 1'b1;
        tick();
        idle();
        reset = 1'b0;
        total++;
        if (flush !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_cancel got=%b%b pc=%h exp=00 pc=00000000",
                     flush, redirect_valid, redirect_pc);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle();
        test_reset();
        test_correct_predict();
        test_mispredict_taken();
        test_mispredict_not_taken();
        test_target_mismatch();
        test_full();
        test_stall();
        test_underflow();
        test_mispredict_concurrent_push();
        test_back_to_back();
        test_reset_cancels_redirect();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
